// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan driver.
// Segment patterns are active-low {g,f,e,d,c,b,a} for a common-anode display.
package seg_scan_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHOW  = 2'd1;
  localparam state_t ST_BLANK = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to active-low seven-segment pattern.
module seg7_hex_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with per-frame value snapshot.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              enable,
  input  logic [4*NUM_DIGITS-1:0]                           value,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] dig_sel,
  output logic [3:0]                                        selected_value,
  output logic [NUM_DIGITS-1:0]                             anode,
  output logic [6:0]                                        segments,
  output logic                                              frame_done
);

  localparam int unsigned SelW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CntMax = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax);

  localparam logic [CntW-1:0] ShowLast  = CntW'(PRESCALE - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [SelW-1:0] LastDig   = SelW'(NUM_DIGITS - 1);

  state_t                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [SelW-1:0]         dig_sel_q, dig_sel_d;
  logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
  logic                    frame_done_q, frame_done_d;
  logic                    advance;
  logic                    take_snap;
  logic [6:0]              dec_seg;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dig_sel_d    = dig_sel_q;
    snap_d       = snap_q;
    frame_done_d = 1'b0;
    advance      = 1'b0;
    take_snap    = 1'b0;

    if (!enable) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      dig_sel_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d   = ST_SHOW;
          cnt_d     = '0;
          dig_sel_d = '0;
          take_snap = 1'b1;
        end
        ST_SHOW: begin
          if (cnt_q == ShowLast) begin
            cnt_d = '0;
            if (BLANK_CYCLES == 0) advance = 1'b1;
            else                   state_d = ST_BLANK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_BLANK: begin
          if (cnt_q == BlankLast) begin
            cnt_d   = '0;
            state_d = ST_SHOW;
            advance = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase

      if (advance) begin
        if (dig_sel_q == LastDig) begin
          dig_sel_d    = '0;
          take_snap    = 1'b1;
          frame_done_d = 1'b1;
        end else begin
          dig_sel_d = dig_sel_q + 1'b1;
        end
      end
    end

    if (take_snap) snap_d = value;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      dig_sel_q    <= '0;
      snap_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dig_sel_q    <= dig_sel_d;
      snap_q       <= snap_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_mask_q, lz_mask_d;
  logic                  upper_zero;

  // Digit k is a leading zero when it and every higher nibble are zero.
  always_comb begin
    lz_mask_d  = lz_mask_q;
    upper_zero = 1'b1;
    if (take_snap) begin
      lz_mask_d = '0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
        upper_zero   = upper_zero & (value[4*k +: 4] == 4'h0);
        lz_mask_d[k] = upper_zero;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lz_mask_q <= '0;
    else     lz_mask_q <= lz_mask_d;
  end
`endif

  always_comb begin
    selected_value = '0;
    anode          = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig_sel_q == SelW'(k)) begin
        selected_value = snap_q[4*k +: 4];
        if (state_q == ST_SHOW) anode[k] = 1'b0;
      end
    end
  end

  seg7_hex_decode u_decode (
    .hex (selected_value),
    .seg (dec_seg)
  );

  always_comb begin
    segments = SEG_BLANK;
    if (state_q == ST_SHOW) segments = dec_seg;
`ifdef LEADING_ZERO_BLANK_EN
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (dig_sel_q == SelW'(k) && lz_mask_q[k]) segments = SEG_BLANK;
    end
`endif
  end

  assign dig_sel    = dig_sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: stimulus queues expected lit-digit runs, a negedge monitor
// assembles each run from the DUT outputs and compares it against the queue.
module tb_seg_scan_driver;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic [1:0] sel;
    logic [3:0] sv;
    logic       fd;
    int         len;
    int         gap;   // -1 = don't care
  } ev_t;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZL = 7'h7F;
`else
  localparam logic [6:0] ZL = 7'h40;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, en_b;
  logic [15:0] val_a, val_b;
  logic [1:0]  sel_a, sel_b;
  logic [3:0]  sv_a, sv_b, an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        fd_a, fd_b;

  int total = 0;
  int bad   = 0;

  ev_t        q0[$];
  ev_t        q1[$];
  logic [3:0] cur_an [2] = '{4'hF, 4'hF};
  ev_t        cur    [2];
  int         dark   [2] = '{0, 0};
  bit         dclean [2] = '{1'b1, 1'b1};
  bit         cln    [2] = '{1'b1, 1'b1};

  always #5 clk = ~clk;

  // dut_b covers the no-gap configuration; dut_a everything else.
  seg_scan_driver #(.NUM_DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1)) dut_a (
    .clk (clk), .rst (rst), .enable (en_a), .value (val_a), .dig_sel (sel_a),
    .selected_value (sv_a), .anode (an_a), .segments (seg_a), .frame_done (fd_a)
  );

  seg_scan_driver #(.NUM_DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(0)) dut_b (
    .clk (clk), .rst (rst), .enable (en_b), .value (val_b), .dig_sel (sel_b),
    .selected_value (sv_b), .anode (an_b), .segments (seg_b), .frame_done (fd_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic finish_run(input int d);
    ev_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL d%0d_unexpected_run: got anode %0h want none", d, cur[d].an);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("d%0d_anode", d), int'(cur[d].an), int'(e.an));
    chk($sformatf("d%0d_seg_an%0h", d, e.an), int'(cur[d].seg), int'(e.seg));
    chk($sformatf("d%0d_dig_sel_an%0h", d, e.an), int'(cur[d].sel), int'(e.sel));
    chk($sformatf("d%0d_selval_an%0h", d, e.an), int'(cur[d].sv), int'(e.sv));
    chk($sformatf("d%0d_frame_done_an%0h", d, e.an), int'(cur[d].fd), int'(e.fd));
    chk($sformatf("d%0d_len_an%0h", d, e.an), cur[d].len, e.len);
    if (e.gap >= 0) chk($sformatf("d%0d_gap_an%0h", d, e.an), cur[d].gap, e.gap);
    chk($sformatf("d%0d_clean_an%0h", d, e.an), int'(cln[d]), 1);
  endtask

  task automatic observe(input int d, input logic [3:0] an, input logic [6:0] seg,
                         input logic [1:0] sel, input logic [3:0] sv, input logic fd);
    if (an != cur_an[d]) begin
      if (cur_an[d] != 4'hF) finish_run(d);
      if (an != 4'hF) begin
        cur[d]  = '{an, seg, sel, sv, fd, 1, dark[d]};
        cln[d]  = dclean[d];
        dark[d] = 0;
      end else begin
        dark[d]   = 1;
        dclean[d] = (seg == 7'h7F) && !fd;
      end
      cur_an[d] = an;
    end else if (an != 4'hF) begin
      cur[d].len++;
      if (seg != cur[d].seg || sel != cur[d].sel || sv != cur[d].sv || fd) cln[d] = 1'b0;
    end else begin
      dark[d]++;
      if (seg != 7'h7F || fd) dclean[d] = 1'b0;
    end
    if (an != 4'hF) dclean[d] = 1'b1;
  endtask

  always @(negedge clk) begin
    observe(0, an_b, seg_b, sel_b, sv_b, fd_b);
    observe(1, an_a, seg_a, sel_a, sv_a, fd_a);
  end

  // segs packs hand-computed patterns {d3,d2,d1,d0}; nd digits pushed, last of length last_len.
  task automatic push_frame(input int d, input logic [15:0] v, input logic [27:0] segs,
                            input logic fd, input int gap0, input int gap, input int nd,
                            input int last_len);
    ev_t e;
    for (int k = 0; k < nd; k++) begin
      e.an  = 4'hF ^ (4'b0001 << k);
      e.seg = segs[7*k +: 7];
      e.sel = 2'(k);
      e.sv  = v[4*k +: 4];
      e.fd  = (k == 0) ? fd : 1'b0;
      e.len = (k == nd - 1) ? last_len : 4;
      e.gap = (k == 0) ? gap0 : gap;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_anode"}, int'(an_a), 'hF);
    chk({tag, "_segments"}, int'(seg_a), 'h7F);
    chk({tag, "_dig_sel"}, int'(sel_a), 0);
    chk({tag, "_selval"}, int'(sv_a), 0);
    chk({tag, "_frame_done"}, int'(fd_a), 0);
  endtask

  initial begin
    rst   = 1'b1;
    en_a  = 1'b0;
    en_b  = 1'b0;
    val_a = '0;
    val_b = '0;
    #12;
    chk_reset("por");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycles(2);

    // No blanking gap: digits abut, two full frames of 8s.
    val_b = 16'h8888;
    en_b  = 1'b1;
    push_frame(0, 16'h8888, {4{7'h00}}, 1'b0, -1, 0, 4, 4);
    push_frame(0, 16'h8888, {4{7'h00}}, 1'b1, 0, 0, 4, 4);
    cycles(32);
    en_b = 1'b0;
    cycles(3);

    // Basic scan of 1234, then a mid-frame value change.
    val_a = 16'h1234;
    en_a  = 1'b1;
    push_frame(1, 16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b0, -1, 1, 4, 4);
    push_frame(1, 16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b1, 1, 1, 4, 4);
    cycles(27);
    val_a = 16'hABCD;
    push_frame(1, 16'hABCD, {7'h08, 7'h03, 7'h46, 7'h21}, 1'b1, 1, 1, 3, 2);

    // Drop enable two cycles into digit 2.
    cycles(25);
    en_a = 1'b0;
    cycles(1);
    chk("disable_anode", int'(an_a), 'hF);
    chk("disable_dig_sel", int'(sel_a), 0);
    chk("disable_frame_done", int'(fd_a), 0);
    val_a = 16'h5A0F;
    en_a  = 1'b1;
    push_frame(1, 16'h5A0F, {7'h12, 7'h08, 7'h40, 7'h0E}, 1'b0, -1, 1, 2, 4);

    // Asynchronous reset in the blank after digit 1.
    cycles(10);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("async_rst");
    @(posedge clk);
    #1;
    rst   = 1'b0;
    val_a = 16'h0050;
    push_frame(1, 16'h0050, {ZL, ZL, 7'h12, 7'h40}, 1'b0, -1, 1, 4, 4);
    push_frame(1, 16'h0000, {ZL, ZL, ZL, 7'h40}, 1'b1, 1, 1, 4, 4);
    cycles(2);
    val_a = 16'h0000;
    cycles(38);
    en_a = 1'b0;
    cycles(4);

    chk("q_b_left", q0.size(), 0);
    chk("q_a_left", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
